// File: rtl/tmds_pkg.sv
// Shared definitions for the TMDS receive lane: control-token codes, alignment
// FSM states and the token-to-control-bits lookup.
package tmds_pkg;

    localparam logic [9:0] TOKEN_C00 = 10'b1101010100;
    localparam logic [9:0] TOKEN_C01 = 10'b0010101011;
    localparam logic [9:0] TOKEN_C10 = 10'b0101010100;
    localparam logic [9:0] TOKEN_C11 = 10'b1010101011;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SLIP   = 2'd1,
        WAIT   = 2'd2,
        LOCKED = 2'd3
    } align_state_t;

    typedef struct packed {
        logic       is_token;
        logic [1:0] c;
    } token_t;

    function automatic token_t token_to_c(input logic [9:0] word);
        token_t t;
        t.is_token = 1'b1;
        t.c        = 2'b00;
        case (word)
            TOKEN_C00: t.c = 2'b00;
            TOKEN_C01: t.c = 2'b01;
            TOKEN_C10: t.c = 2'b10;
            TOKEN_C11: t.c = 2'b11;
            default:   t.is_token = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/tmds_channel_decoder_if.sv
// Lane-level bus between the deserializer/consumer side (master) and the
// channel decoder (slave).
interface tmds_channel_decoder_if;

    logic [9:0] in_tmds;
    logic       out_bitslip;
    logic       out_locked;
    logic [7:0] out_data;
    logic [1:0] out_c;
    logic       out_de;

    modport master (
        output in_tmds,
        input  out_bitslip,
        input  out_locked,
        input  out_data,
        input  out_c,
        input  out_de
    );

    modport slave (
        input  in_tmds,
        output out_bitslip,
        output out_locked,
        output out_data,
        output out_c,
        output out_de
    );

endinterface

// File: rtl/tmds_word_decode.sv
// Purely combinational 10b-to-8b TMDS word decoder: flags control tokens and
// undoes the optional inversion and XOR/XNOR transition coding of data words.
module tmds_word_decode
    import tmds_pkg::*;
(
    input  logic [9:0] word,
    output logic       is_token,
    output logic [1:0] c,
    output logic [7:0] data
);

    token_t     tok;
    logic [7:0] d;

    always_comb begin
        tok      = token_to_c(word);
        is_token = tok.is_token;
        c        = tok.c;
        d        = word[9] ? ~word[7:0] : word[7:0];
        data     = '0;
        if (!tok.is_token) begin
            data[0] = d[0];
            for (int i = 1; i < 8; i++) begin
                data[i] = word[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
            end
        end
    end

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS receive lane: two-stage decode pipeline plus the bitslip-driven
// word-alignment FSM that hunts for stable runs of control tokens.
module tmds_channel_decoder
    import tmds_pkg::*;
#(
    parameter int C_lock_tokens   = 8,
    parameter int C_search_window = 1024,
    parameter int C_slip_wait     = 16
) (
    input  logic clk_pixel,
    input  logic reset,
    tmds_channel_decoder_if.slave bus
);

    localparam int RUN_W  = $clog2(C_lock_tokens + 1);
    localparam int WIN_W  = $clog2(C_search_window);
    localparam int WAIT_W = $clog2(C_slip_wait);

    localparam logic [RUN_W-1:0]  RUN_FULL  = RUN_W'(C_lock_tokens);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(C_search_window - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(C_slip_wait - 1);

    logic [9:0]        s1_word;
    logic              dec_is_token;
    logic [1:0]        dec_c;
    logic [7:0]        dec_data;
    logic [7:0]        data_q;
    logic [1:0]        c_q;
    logic              de_q;

    logic [RUN_W-1:0]  token_run;
    logic [WIN_W-1:0]  window;
    logic [WAIT_W-1:0] wait_cnt;
    logic              run_full;
    logic              window_last;
    logic              wait_done;

    align_state_t      state;
    align_state_t      state_next;
    logic              bitslip;
    logic              locked;
    logic              clear_counters;

    tmds_word_decode u_decode (
        .word     (s1_word),
        .is_token (dec_is_token),
        .c        (dec_c),
        .data     (dec_data)
    );

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            s1_word <= '0;
            data_q  <= '0;
            c_q     <= '0;
            de_q    <= 1'b0;
        end else begin
            s1_word <= bus.in_tmds;
            data_q  <= dec_data;
            de_q    <= ~dec_is_token;
            if (dec_is_token) begin
                c_q <= dec_c;
            end
        end
    end

    assign run_full    = (token_run == RUN_FULL);
    assign window_last = (window == WIN_LAST);
    assign wait_done   = (wait_cnt == WAIT_LAST);

    // A completed token run always beats window expiry in the same cycle.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            token_run <= '0;
            window    <= '0;
            wait_cnt  <= '0;
        end else begin
            if (clear_counters) begin
                token_run <= '0;
                window    <= '0;
            end else begin
                if (!dec_is_token) begin
                    token_run <= '0;
                end else if (!run_full) begin
                    token_run <= token_run + RUN_W'(1);
                end
                window <= run_full ? '0 : window + WIN_W'(1);
            end
            if (state == WAIT && !wait_done) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            state <= SEARCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            SEARCH: begin
                if (run_full) begin
                    state_next = LOCKED;
                end else if (window_last) begin
                    state_next = SLIP;
                end
            end
            SLIP:   state_next = WAIT;
            WAIT:   if (wait_done) state_next = SEARCH;
            LOCKED: if (!run_full && window_last) state_next = SEARCH;
            default: state_next = SEARCH;
        endcase
    end

    // Counters are held clear while the deserializer settles after a slip.
    always_comb begin
        bitslip        = 1'b0;
        locked         = 1'b0;
        clear_counters = 1'b0;
        case (state)
            SLIP: begin
                bitslip        = 1'b1;
                clear_counters = 1'b1;
            end
            WAIT: clear_counters = 1'b1;
            LOCKED: begin
                locked         = 1'b1;
                clear_counters = !run_full && window_last;
            end
            default: ;
        endcase
    end

    assign bus.out_bitslip = bitslip;
    assign bus.out_locked  = locked;
    assign bus.out_data    = data_q;
    assign bus.out_c       = c_q;
    assign bus.out_de      = de_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Self-checking bench for one TMDS lane: a DVI encoder model supplies data words
// and a rotating-deserializer model answers bitslip pulses.
module tb_tmds_channel_decoder;

    localparam int SLIP_GAP_MIN = 1024 + 16 + 1;

    logic clk_pixel = 1'b0;
    logic reset     = 1'b1;

    tmds_channel_decoder_if bus ();

    tmds_channel_decoder #(
        .C_lock_tokens   (8),
        .C_search_window (1024),
        .C_slip_wait     (16)
    ) dut (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .bus       (bus)
    );

    always #5 clk_pixel = ~clk_pixel;

    int         error_count = 0;
    int         check_count = 0;
    int         edge_idx = 0;
    int         slip_count = 0;
    int         last_slip_edge = 0;
    int         rot_offset = 0;
    int         enc_disp = 0;
    logic       slip_high = 1'b0;
    logic       prev_chk = 1'b0;
    logic [7:0] prev_data = '0;
    logic [1:0] prev_c = '0;
    logic       prev_de = 1'b0;
    logic [1:0] exp_c = '0;
    logic [9:0] token_table [4];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", tag, observed, expected, edge_idx);
        end
    endtask

    // Reference DVI 1.0 encoder, including running-disparity balancing.
    function automatic logic [9:0] tmds_encode(input logic [7:0] b);
        logic [8:0] qm;
        logic [9:0] q;
        int n1, n1q, n0q;
        n1    = $countones(b);
        qm[0] = b[0];
        if (n1 > 4 || (n1 == 4 && b[0] == 1'b0)) begin
            for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ b[i]);
            qm[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ b[i];
            qm[8] = 1'b1;
        end
        n1q = $countones(qm[7:0]);
        n0q = 8 - n1q;
        if (enc_disp == 0 || n1q == n0q) begin
            q = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
            enc_disp += qm[8] ? (n1q - n0q) : (n0q - n1q);
        end else if ((enc_disp > 0 && n1q > n0q) || (enc_disp < 0 && n0q > n1q)) begin
            q = {1'b1, qm[8], ~qm[7:0]};
            enc_disp += (qm[8] ? 2 : 0) + (n0q - n1q);
        end else begin
            q = {1'b0, qm[8], qm[7:0]};
            enc_disp += (qm[8] ? 0 : -2) + (n1q - n0q);
        end
        return q;
    endfunction

    function automatic logic [9:0] rotate_word(input logic [9:0] w, input int k);
        logic [19:0] dbl;
        dbl = {w, w};
        return dbl[k +: 10];
    endfunction

    task automatic applyStimulus(input logic [9:0] word, input logic chk, input logic [7:0] e_data,
                                 input logic [1:0] e_c, input logic e_de);
        bus.in_tmds = word;
        @(posedge clk_pixel);
        #1;
        edge_idx++;
        if (slip_high) checkOutput("slip_width", 32'(bus.out_bitslip), 32'd0);
        slip_high = bus.out_bitslip;
        if (bus.out_bitslip) begin
            slip_count++;
            if (slip_count > 1) checkOutput("slip_gap", 32'(edge_idx - last_slip_edge >= SLIP_GAP_MIN), 32'd1);
            last_slip_edge = edge_idx;
            rot_offset     = (rot_offset + 1) % 10;
        end
        if (prev_chk) begin
            checkOutput("out_data", 32'(bus.out_data), 32'(prev_data));
            checkOutput("out_c", 32'(bus.out_c), 32'(prev_c));
            checkOutput("out_de", 32'(bus.out_de), 32'(prev_de));
        end
        prev_chk  = chk;
        prev_data = e_data;
        prev_c    = e_c;
        prev_de   = e_de;
    endtask

    task automatic send_byte(input logic [7:0] b);
        applyStimulus(tmds_encode(b), 1'b1, b, exp_c, 1'b1);
    endtask

    task automatic send_token(input logic [1:0] c);
        exp_c = c;
        applyStimulus(token_table[c], 1'b1, 8'h00, c, 1'b0);
    endtask

    task automatic send_tokens(input logic [1:0] c, input int n);
        repeat (n) send_token(c);
    endtask

    task automatic send_rotated_blank();
        applyStimulus(rotate_word(token_table[0], rot_offset), 1'b0, 8'h00, 2'b00, 1'b0);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        bus.in_tmds = '0;
        repeat (2) @(posedge clk_pixel);
        #2;
        reset          = 1'b0;
        edge_idx       = 0;
        slip_count     = 0;
        last_slip_edge = 0;
        slip_high      = 1'b0;
        prev_chk       = 1'b0;
        rot_offset     = 0;
        exp_c          = '0;
        enc_disp       = 0;
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_bitslip"}, 32'(bus.out_bitslip), 32'd0);
        checkOutput({tag, "_locked"}, 32'(bus.out_locked), 32'd0);
        checkOutput({tag, "_data"}, 32'(bus.out_data), 32'd0);
        checkOutput({tag, "_c"}, 32'(bus.out_c), 32'd0);
        checkOutput({tag, "_de"}, 32'(bus.out_de), 32'd0);
    endtask

    // Eight aligned blank tokens from reset: lock visible after the 10th edge.
    task automatic check_aligned_lock(input string tag);
        for (int i = 0; i < 12; i++) begin
            send_token(2'b00);
            if (edge_idx == 9) checkOutput({tag, "_unlocked_e9"}, 32'(bus.out_locked), 32'd0);
            if (edge_idx == 10) begin
                checkOutput({tag, "_locked_e10"}, 32'(bus.out_locked), 32'd1);
                checkOutput({tag, "_c_e10"}, 32'(bus.out_c), 32'd0);
                checkOutput({tag, "_de_e10"}, 32'(bus.out_de), 32'd0);
            end
        end
        checkOutput({tag, "_no_slip"}, 32'(slip_count), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   n0;
        logic found;
        logic dropped;

        token_table[0] = 10'b1101010100;
        token_table[1] = 10'b0010101011;
        token_table[2] = 10'b0101010100;
        token_table[3] = 10'b1010101011;

        do_reset();
        check_all_zero("reset");
        check_aligned_lock("align");

        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        send_byte(8'h10);
        for (int line = 0; line < 6; line++) begin
            send_tokens(2'($urandom_range(0, 3)), int'($urandom_range(8, 12)));
            repeat ($urandom_range(100, 300)) send_byte(8'($urandom));
        end
        checkOutput("data_phase_locked", 32'(bus.out_locked), 32'd1);
        checkOutput("data_phase_slips", 32'(slip_count), 32'd0);

        // A full token run ending at word n0 restarts the window; 1024 counts later lock drops.
        send_tokens(2'b01, 8);
        n0 = edge_idx;
        for (int i = 0; i < 1100; i++) begin
            send_byte(8'($urandom));
            if (edge_idx == n0 + 1025) checkOutput("unlock_hold", 32'(bus.out_locked), 32'd1);
            if (edge_idx == n0 + 1026) checkOutput("unlock_drop", 32'(bus.out_locked), 32'd0);
        end
        checkOutput("unlock_no_slip", 32'(slip_count), 32'd0);
        checkOutput("unlock_searching", 32'(bus.out_locked), 32'd0);

        do_reset();
        send_tokens(2'b00, 7);
        send_byte(8'($urandom));
        for (int i = 0; i < 12; i++) begin
            send_token(2'b00);
            if (edge_idx == 17) checkOutput("run7_not_locked", 32'(bus.out_locked), 32'd0);
            if (edge_idx == 18) checkOutput("run8_locked", 32'(bus.out_locked), 32'd1);
        end

        // Run completion lands in the same cycle as the first window expiry.
        do_reset();
        repeat (1014) send_byte(8'($urandom));
        for (int i = 0; i < 16; i++) begin
            send_token(2'b10);
            if (edge_idx == 1023) checkOutput("tie_search_pre", 32'(bus.out_locked), 32'd0);
            if (edge_idx == 1024) checkOutput("tie_search_lock", 32'(bus.out_locked), 32'd1);
        end
        checkOutput("tie_search_no_slip", 32'(slip_count), 32'd0);

        send_tokens(2'b11, 10);
        n0      = edge_idx;
        dropped = 1'b0;
        repeat (1016) begin
            send_byte(8'($urandom));
            if (!bus.out_locked) dropped = 1'b1;
        end
        repeat (20) begin
            send_token(2'b11);
            if (!bus.out_locked) dropped = 1'b1;
        end
        checkOutput("tie_locked_kept", 32'(dropped), 32'd0);
        checkOutput("tie_locked_final", 32'(bus.out_locked), 32'd1);
        checkOutput("tie_locked_no_slip", 32'(slip_count), 32'd0);

        // Deserializer starts 3 bits off; seven slips wrap it back into alignment.
        do_reset();
        rot_offset = 3;
        for (int i = 0; i < 9000 && !bus.out_locked; i++) send_rotated_blank();
        checkOutput("rot_locked", 32'(bus.out_locked), 32'd1);
        checkOutput("rot_slip_count", 32'(slip_count), 32'd7);
        checkOutput("rot_offset_aligned", 32'(rot_offset), 32'd0);
        repeat (1500) send_rotated_blank();
        checkOutput("rot_no_extra_slips", 32'(slip_count), 32'd7);
        checkOutput("rot_still_locked", 32'(bus.out_locked), 32'd1);

        do_reset();
        found = 1'b0;
        for (int i = 0; i < 1100 && !found; i++) begin
            send_byte(8'($urandom));
            found = bus.out_bitslip;
        end
        checkOutput("slip_seen", 32'(found), 32'd1);
        checkOutput("first_slip_edge", 32'(edge_idx), 32'd1024);
        reset = 1'b1;
        #1;
        check_all_zero("mid_slip_reset");
        do_reset();
        check_aligned_lock("relock");

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
